// File: rtl/dcls_pkg.sv
// Shared encodings and parameter defaults for the lockstep fault manager.
package dcls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_RECOVER = 3'd2,
    ST_SYNC    = 3'd3,
    ST_FATAL   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISMATCH = 2'b01,
    CAUSE_DED      = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

  localparam int unsigned DEF_CONFIRM_CYCLES = 2;
  localparam int unsigned DEF_RESET_CYCLES   = 4;
  localparam int unsigned DEF_SYNC_CYCLES    = 2;
  localparam int unsigned DEF_MAX_RETRIES    = 3;
  localparam int unsigned DEF_QUIET_CYCLES   = 64;

  function automatic cause_e pick_cause(
    input logic ded,
    input logic ill
  );
    if (ded)      return CAUSE_DED;
    else if (ill) return CAUSE_ILLEGAL;
    else          return CAUSE_MISMATCH;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/dcls_fault_manager.sv
// Lockstep fault manager: confirms mismatches, sequences core recovery,
// escalates to FATAL after repeated retries and keeps event statistics.
module dcls_fault_manager
  import dcls_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int unsigned SYNC_CYCLES    = DEF_SYNC_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int unsigned QUIET_CYCLES   = DEF_QUIET_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mismatch_flag,
  input  logic        single_error_corrected,
  input  logic        double_error_detected,
  input  logic        unrecognized_instruction,
  input  logic [31:0] final_output,
  input  logic        clear_req,
  output logic        core_reset_req,
  output logic [2:0]  fault_state,
  output logic        fatal,
  output logic [15:0] sec_count,
  output logic [15:0] ded_count,
  output logic [15:0] mismatch_count,
  output logic [1:0]  retry_count,
  output logic [31:0] fault_data,
  output logic [1:0]  fault_cause
);

  localparam int unsigned TW =
    $clog2(CONFIRM_CYCLES + RESET_CYCLES + SYNC_CYCLES + 1) + 1;
  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

  state_e      state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [1:0]  retry_q, retry_d;
  logic [31:0] data_q, data_d;
  cause_e      cause_q, cause_d;
  logic        rst_req_q, rst_req_d;
  logic        fatal_q, fatal_d;

  logic trig;
  logic mm_confirm;
  logic hard_fault;

  assign hard_fault = double_error_detected | unrecognized_instruction;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    quiet_d    = '0;
    retry_d    = clear_req ? 2'd0 : retry_q;
    data_d     = data_q;
    cause_d    = cause_q;
    trig       = 1'b0;
    mm_confirm = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (hard_fault) begin
          trig = 1'b1;
        end else if (mismatch_flag) begin
          if (CONFIRM_CYCLES <= 1) begin
            trig       = 1'b1;
            mm_confirm = 1'b1;
          end else begin
            state_d = ST_CONFIRM;
            tmr_d   = TW'(1);
          end
        end else if (quiet_q == QW'(QUIET_CYCLES - 1)) begin
          retry_d = 2'd0;
        end else begin
          quiet_d = quiet_q + QW'(1);
        end
      end
      ST_CONFIRM: begin
        if (hard_fault) begin
          trig = 1'b1;
        end else if (mismatch_flag) begin
          if ((tmr_q + TW'(1)) >= TW'(CONFIRM_CYCLES)) begin
            trig       = 1'b1;
            mm_confirm = 1'b1;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (tmr_q == TW'(RESET_CYCLES - 1)) begin
          state_d = ST_SYNC;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_SYNC: begin
        if (tmr_q == TW'(SYNC_CYCLES - 1)) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_FATAL: begin
        if (clear_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Retry budget is judged on the count held before this trigger.
    if (trig) begin
      data_d  = final_output;
      cause_d = pick_cause(double_error_detected,
                           unrecognized_instruction);
      tmr_d   = '0;
      if (retry_q == 2'(MAX_RETRIES)) begin
        state_d = ST_FATAL;
      end else begin
        state_d = ST_RECOVER;
        retry_d = retry_d + 2'd1;
      end
    end

    rst_req_d = (state_d == ST_RECOVER) || (state_d == ST_FATAL);
    fatal_d   = (state_d == ST_FATAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      quiet_q   <= '0;
      retry_q   <= '0;
      data_q    <= '0;
      cause_q   <= CAUSE_NONE;
      rst_req_q <= 1'b0;
      fatal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      quiet_q   <= quiet_d;
      retry_q   <= retry_d;
      data_q    <= data_d;
      cause_q   <= cause_d;
      rst_req_q <= rst_req_d;
      fatal_q   <= fatal_d;
    end
  end

  sat_counter16 u_sec_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (single_error_corrected && (state_q != ST_SYNC)),
    .count (sec_count)
  );

  sat_counter16 u_ded_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (double_error_detected && (state_q != ST_SYNC)),
    .count (ded_count)
  );

  sat_counter16 u_mm_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (mm_confirm),
    .count (mismatch_count)
  );

  assign core_reset_req = rst_req_q;
  assign fault_state    = state_q;
  assign fatal          = fatal_q;
  assign retry_count    = retry_q;
  assign fault_data     = data_q;
  assign fault_cause    = cause_q;

endmodule

// File: tb/tb_dcls_fault_manager.sv
// Bench for dcls_fault_manager: directed table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_dcls_fault_manager;

  localparam int CONF  = 2;
  localparam int RSTC  = 4;
  localparam int SYNCC = 2;
  localparam int MAXR  = 3;
  localparam int QUIET = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mm = 1'b0;
  logic        sec = 1'b0;
  logic        ded = 1'b0;
  logic        ill = 1'b0;
  logic [31:0] din = '0;
  logic        clr = 1'b0;
  logic        core_reset_req;
  logic [2:0]  fault_state;
  logic        fatal;
  logic [15:0] sec_count;
  logic [15:0] ded_count;
  logic [15:0] mismatch_count;
  logic [1:0]  retry_count;
  logic [31:0] fault_data;
  logic [1:0]  fault_cause;

  int n_vec = 0;
  int n_bad = 0;

  dcls_fault_manager dut (
    .clk                      (clk),
    .reset                    (reset),
    .mismatch_flag            (mm),
    .single_error_corrected   (sec),
    .double_error_detected    (ded),
    .unrecognized_instruction (ill),
    .final_output             (din),
    .clear_req                (clr),
    .core_reset_req           (core_reset_req),
    .fault_state              (fault_state),
    .fatal                    (fatal),
    .sec_count                (sec_count),
    .ded_count                (ded_count),
    .mismatch_count           (mismatch_count),
    .retry_count              (retry_count),
    .fault_data               (fault_data),
    .fault_cause              (fault_cause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"}, 32'(fault_state), 32'd0);
    chk({tag, " rst_req"}, 32'(core_reset_req), 32'd0);
    chk({tag, " fatal"}, 32'(fatal), 32'd0);
    chk({tag, " sec"}, 32'(sec_count), 32'd0);
    chk({tag, " ded"}, 32'(ded_count), 32'd0);
    chk({tag, " mmc"}, 32'(mismatch_count), 32'd0);
    chk({tag, " retry"}, 32'(retry_count), 32'd0);
    chk({tag, " data"}, fault_data, 32'd0);
    chk({tag, " cause"}, 32'(fault_cause), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {mm, sec, ded, ill, clr} = '0;
    din = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        mm, ded, ill, clr;
    logic [31:0] din;
    logic [2:0]  st;
    logic        rr;
    logic [1:0]  rt, ca;
    logic [31:0] fd;
    logic [15:0] mc, dc;
  } vec_t;

  vec_t tbl[17];

  // Reference model state: plain integers, phase length as a countdown.
  int m_state, m_left, m_streak, m_retry, m_quiet;
  int m_sec, m_ded, m_mmc, m_cause;
  logic [31:0] m_data;

  task automatic model_init();
    m_state = 0; m_left = 0; m_streak = 0; m_retry = 0; m_quiet = 0;
    m_sec = 0; m_ded = 0; m_mmc = 0; m_cause = 0; m_data = '0;
  endtask

  task automatic model_step(input bit i_mm, input bit i_sec,
                            input bit i_ded, input bit i_ill,
                            input bit i_clr, input logic [31:0] i_d);
    bit fire = 0;
    int r = i_clr ? 0 : m_retry;
    int q = m_quiet;
    m_quiet = 0;
    if (m_state != 3) begin
      if (i_sec && m_sec < 65535) m_sec++;
      if (i_ded && m_ded < 65535) m_ded++;
    end
    case (m_state)
      0: begin
        if (i_ded || i_ill) fire = 1;
        else if (i_mm) begin
          m_streak = 1;
          if (m_streak >= CONF) fire = 1;
          else m_state = 1;
        end else begin
          q++;
          if (q == QUIET) r = 0;
          else m_quiet = q;
        end
      end
      1: begin
        if (i_ded || i_ill) fire = 1;
        else if (i_mm) begin
          m_streak++;
          if (m_streak >= CONF) fire = 1;
        end else m_state = 0;
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_state = 3; m_left = SYNCC; end
      end
      3: begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
      default: if (i_clr) m_state = 0;
    endcase
    if (fire) begin
      m_cause = i_ded ? 2 : (i_ill ? 3 : 1);
      if (m_cause == 1 && m_mmc < 65535) m_mmc++;
      m_data = i_d;
      if (m_retry == MAXR) m_state = 4;
      else begin
        m_state = 2;
        m_left  = RSTC;
        r = r + 1;
      end
    end
    m_retry = r;
  endtask

  initial begin
    int saturated_changes;
    tbl[0]  = '{1,0,0,0,32'h0,        1,0,0,0,32'h0,        0,0};
    tbl[1]  = '{0,0,0,0,32'h0,        0,0,0,0,32'h0,        0,0};
    tbl[2]  = '{1,0,0,0,32'hDEADBEEF, 1,0,0,0,32'h0,        0,0};
    tbl[3]  = '{1,0,0,0,32'hDEADBEEF, 2,1,1,1,32'hDEADBEEF, 1,0};
    tbl[4]  = '{0,0,0,0,32'h0,        2,1,1,1,32'hDEADBEEF, 1,0};
    tbl[5]  = '{0,0,0,0,32'h0,        2,1,1,1,32'hDEADBEEF, 1,0};
    tbl[6]  = '{0,0,0,0,32'h0,        2,1,1,1,32'hDEADBEEF, 1,0};
    tbl[7]  = '{0,0,0,0,32'h0,        3,0,1,1,32'hDEADBEEF, 1,0};
    tbl[8]  = '{0,0,0,0,32'h0,        3,0,1,1,32'hDEADBEEF, 1,0};
    tbl[9]  = '{0,0,0,0,32'h0,        0,0,1,1,32'hDEADBEEF, 1,0};
    tbl[10] = '{1,1,0,0,32'h12345678, 2,1,2,2,32'h12345678, 1,1};
    tbl[11] = '{0,0,0,0,32'h0,        2,1,2,2,32'h12345678, 1,1};
    tbl[12] = '{0,0,0,0,32'h0,        2,1,2,2,32'h12345678, 1,1};
    tbl[13] = '{0,0,0,0,32'h0,        2,1,2,2,32'h12345678, 1,1};
    tbl[14] = '{0,0,0,0,32'h0,        3,0,2,2,32'h12345678, 1,1};
    tbl[15] = '{1,1,1,0,32'hAAAA5555, 3,0,2,2,32'h12345678, 1,1};
    tbl[16] = '{0,0,0,0,32'h0,        0,0,2,2,32'h12345678, 1,1};

    reset = 1'b1;
    step();
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      mm = tbl[i].mm; ded = tbl[i].ded; ill = tbl[i].ill;
      clr = tbl[i].clr; din = tbl[i].din;
      step();
      chk($sformatf("v%0d state", i), 32'(fault_state), 32'(tbl[i].st));
      chk($sformatf("v%0d rst_req", i), 32'(core_reset_req), 32'(tbl[i].rr));
      chk($sformatf("v%0d fatal", i), 32'(fatal), 32'(tbl[i].st == 3'd4));
      chk($sformatf("v%0d retry", i), 32'(retry_count), 32'(tbl[i].rt));
      chk($sformatf("v%0d cause", i), 32'(fault_cause), 32'(tbl[i].ca));
      chk($sformatf("v%0d data", i), fault_data, tbl[i].fd);
      chk($sformatf("v%0d mmc", i), 32'(mismatch_count), 32'(tbl[i].mc));
      chk($sformatf("v%0d ded", i), 32'(ded_count), 32'(tbl[i].dc));
    end
    {mm, ded, ill, clr} = '0;
    din = '0;

    // Quiet window: retries survive 63 idle cycles, vanish on the 64th.
    repeat (QUIET - 1) step();
    chk("quiet 63", 32'(retry_count), 32'd2);
    step();
    chk("quiet 64", 32'(retry_count), 32'd0);

    // Four DED triggers back to back: three recoveries then FATAL.
    for (int k = 0; k < 4; k++) begin
      ded = 1'b1; din = 32'(k);
      step();
      ded = 1'b0;
      if (k < 3) begin
        chk($sformatf("ded%0d state", k), 32'(fault_state), 32'd2);
        chk($sformatf("ded%0d retry", k), 32'(retry_count), 32'(k + 1));
        repeat (RSTC + SYNCC) step();
        chk($sformatf("ded%0d back", k), 32'(fault_state), 32'd0);
        step();
      end else begin
        chk("fatal state", 32'(fault_state), 32'd4);
        chk("fatal flag", 32'(fatal), 32'd1);
        chk("fatal retry", 32'(retry_count), 32'd3);
      end
    end
    ded = 1'b1;
    step();
    ded = 1'b0;
    repeat (4) step();
    chk("fatal hold", 32'(fault_state), 32'd4);
    chk("fatal rst_req", 32'(core_reset_req), 32'd1);
    chk("fatal dedcnt", 32'(ded_count), 32'd6);
    chk("fatal data", fault_data, 32'd3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear state", 32'(fault_state), 32'd0);
    chk("clear retry", 32'(retry_count), 32'd0);
    chk("clear fatal", 32'(fatal), 32'd0);
    chk("clear rst_req", 32'(core_reset_req), 32'd0);

    // clear_req during SYNC drops retries but not the sequence.
    ill = 1'b1; din = 32'h0BAD0BAD;
    step();
    ill = 1'b0;
    chk("ill cause", 32'(fault_cause), 32'd3);
    chk("ill retry", 32'(retry_count), 32'd1);
    repeat (RSTC) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sync clr state", 32'(fault_state), 32'd3);
    chk("sync clr retry", 32'(retry_count), 32'd0);
    step();
    chk("sync clr idle", 32'(fault_state), 32'd0);

    // Async reset on the second RECOVER cycle.
    ded = 1'b1;
    step();
    ded = 1'b0;
    step();
    chk("pre-reset rst_req", 32'(core_reset_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async");
    step();
    reset = 1'b0;

    // SEC saturation.
    saturated_changes = 0;
    sec = 1'b1;
    for (int i = 1; i <= 70000; i++) begin
      step();
      if (i == 65534) chk("sec 65534", 32'(sec_count), 32'hFFFE);
      if (i == 65535) chk("sec 65535", 32'(sec_count), 32'hFFFF);
      if (i > 65535 && sec_count !== 16'hFFFF) saturated_changes++;
    end
    sec = 1'b0;
    chk("sec saturated", 32'(sec_count), 32'hFFFF);
    chk("sec stuck", 32'(saturated_changes), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    model_init();
    step();
    for (int c = 0; c < 2000; c++) begin
      mm  = ($urandom_range(99, 0) < 30);
      sec = ($urandom_range(99, 0) < 20);
      ded = ($urandom_range(99, 0) < 3);
      ill = ($urandom_range(99, 0) < 3);
      clr = ($urandom_range(99, 0) < 3);
      din = $urandom;
      model_step(mm, sec, ded, ill, clr, din);
      step();
      chk($sformatf("rnd%0d ctl", c),
          {22'd0, fault_state, core_reset_req, fatal, retry_count,
           fault_cause},
          {22'd0, 3'(m_state), 1'(m_state == 2 || m_state == 4),
           1'(m_state == 4), 2'(m_retry), 2'(m_cause)});
      chk($sformatf("rnd%0d data", c), fault_data, m_data);
      chk($sformatf("rnd%0d cnt", c),
          {sec_count, ded_count}, {16'(m_sec), 16'(m_ded)});
      chk($sformatf("rnd%0d mmc", c), 32'(mismatch_count), 32'(m_mmc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcls_fault_manager.md
DCLS_FAULT_MANAGER -- requirements
Module: dcls_fault_manager

Interface
REQ-001 The module SHALL expose parameter CONFIRM_CYCLES, default 2: consecutive mismatch cycles needed to confirm a lockstep fault.
REQ-002 The module SHALL expose parameter RESET_CYCLES, default 4: cycles core_reset_req is held per recovery.
REQ-003 The module SHALL expose parameter SYNC_CYCLES, default 2: settle cycles after recovery, equal to the shadow-core delay.
REQ-004 The module SHALL expose parameter MAX_RETRIES, default 3: recoveries allowed before FATAL.
REQ-005 The module SHALL expose parameter QUIET_CYCLES, default 64: fault-free IDLE cycles that clear the retry count.
REQ-006 Ports SHALL be as follows:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mismatch_flag  in  1  lockstep comparator mismatch.
- single_error_corrected  in  1  MDMHC single-error correction event.
- double_error_detected  in  1  MDMHC uncorrectable error.
- unrecognized_instruction  in  1  either core decoded an illegal opcode.
- final_output  in  32  corrected core result.
- clear_req  in  1  software acknowledge; leaves FATAL, clears retries.
- core_reset_req  out  1  drives the lockstep pair reset.
- fault_state  out  3  FSM state encoding.
- fatal  out  1  high in FATAL.
- sec_count  out  16  saturating SEC count.
- ded_count  out  16  saturating DED count.
- mismatch_count  out  16  saturating confirmed-mismatch count.
- retry_count  out  2  recoveries since last clear.
- fault_data  out  32  final_output captured at the last triggering fault.
- fault_cause  out  2  cause of the last trigger: 01 mismatch, 10 DED, 11 illegal instruction.

Function
REQ-007 The FSM SHALL use states IDLE=0, CONFIRM=1, RECOVER=2, SYNC=3, FATAL=4.
REQ-008 IDLE: DED or unrecognized_instruction SHALL go to RECOVER next cycle; mismatch_flag alone SHALL go to CONFIRM.
REQ-009 CONFIRM: mismatch_flag high for CONFIRM_CYCLES consecutive cycles, including the entry cycle, SHALL go to RECOVER; a low cycle SHALL return to IDLE with no count change.
REQ-010 DED during CONFIRM SHALL go to RECOVER immediately, with fault_cause=10.
REQ-011 On each RECOVER entry, fault_data and fault_cause SHALL be captured from the triggering cycle and retry_count SHALL increment.
REQ-012 If retry_count already equals MAX_RETRIES at the trigger, the FSM SHALL go to FATAL instead of RECOVER, and retry_count SHALL not increment.
REQ-013 core_reset_req SHALL be high for exactly RESET_CYCLES cycles in RECOVER, registered output.
REQ-014 The FSM SHALL then enter SYNC, where all fault inputs are ignored for SYNC_CYCLES cycles, then return to IDLE.
REQ-015 FATAL: core_reset_req SHALL be held high and fatal=1; clear_req SHALL move the FSM to IDLE and zero retry_count.
REQ-016 clear_req in any other state SHALL zero retry_count only.
REQ-017 A single cycle with several causes SHALL record priority DED > illegal instruction > mismatch in fault_cause.
REQ-018 sec_count SHALL increment on every single_error_corrected cycle in every state except SYNC.
REQ-019 ded_count SHALL increment on every DED cycle in every state except SYNC.
REQ-020 mismatch_count SHALL increment once per confirmed mismatch.
REQ-021 All three event counters SHALL saturate at 16'hFFFF.
REQ-022 A quiet counter SHALL count consecutive IDLE cycles with no fault input; reaching QUIET_CYCLES SHALL zero retry_count and restart the quiet count.

Reset
REQ-023 Asynchronous reset SHALL force: state IDLE; core_reset_req=0; fatal=0; all counters=0; fault_data=0; fault_cause=00.
REQ-024 Reset asserted mid-RECOVER or mid-FATAL SHALL deassert core_reset_req in the same cycle, without waiting for a clock edge.

Structure
REQ-025 A shared package dcls_pkg SHALL hold the state encoding, the fault_cause encoding and the parameter defaults.
REQ-026 One sub-module, sat_counter16 (increment enable, synchronous clear, saturation), SHALL be instantiated three times.

Verification
REQ-027 mismatch_flag high for 1 cycle -> CONFIRM then IDLE; mismatch_count=0; core_reset_req stays 0.
REQ-028 mismatch_flag high for 2 cycles with final_output=32'hDEADBEEF -> RECOVER; core_reset_req high 4 cycles; SYNC 2 cycles; IDLE; mismatch_count=1; retry_count=1; fault_data=32'hDEADBEEF; fault_cause=01.
REQ-029 DED and mismatch in the same cycle -> fault_cause=10; ded_count=1; recovery starts next cycle.
REQ-030 Four DED triggers separated by fewer than 64 quiet cycles -> three recoveries, then FATAL with fatal=1 and core_reset_req held; clear_req -> IDLE, retry_count=0.
REQ-031 Drive 70000 SEC pulses -> sec_count=16'hFFFF; output never changes.
REQ-032 Assert reset on the 2nd RECOVER cycle -> core_reset_req=0 and all outputs at reset values before the next clock edge.
